// File: rtl/mem_writeback.sv
// mem_writeback: MIPS memory-access/writeback stage with dmem req/ready handshake.
// Optional access watchdog enabled by defining MEM_WB_TIMEOUT_EN.
module mem_writeback #(
  parameter int TO_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  m,
  input  logic [1:0]  wb,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  output logic        hold_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        reg_write,
  output logic [4:0]  write_register,
  output logic [31:0] write_data_reg,
  output logic        mem_error
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state;
  logic        lat_load;
  logic [1:0]  lat_wb;
  logic [4:0]  lat_dest;
  logic        is_mem, new_wr, done, comp_wr, conflict, accept, abort;
  logic        unused_branch;
  assign unused_branch = m[2];
  assign is_mem   = m[1] | m[0];
  assign new_wr   = !is_mem && wb[1] && dest_reg != 5'd0;
  assign done     = state == ACCESS && dmem_ready;
  assign comp_wr  = done && lat_load && lat_wb[1] && lat_dest != 5'd0;
  // a writing load completion owns the write port, so a writing non-mem op waits one cycle
  assign conflict = comp_wr && in_valid && new_wr;
  assign hold_mem = state == ACCESS && (!dmem_ready || conflict);
  assign accept   = in_valid && !hold_mem;
`ifdef MEM_WB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES) + 1;
  logic [CW-1:0] cnt;
  assign abort = state == ACCESS && !dmem_ready && cnt == CW'(TO_CYCLES - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (state == ACCESS && !dmem_ready && !abort) ? cnt + 1'b1 : '0;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      lat_load       <= 1'b0;
      lat_wb         <= '0;
      lat_dest       <= '0;
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data_reg <= '0;
      mem_error      <= 1'b0;
    end else begin
      reg_write      <= comp_wr || (accept && new_wr);
      write_register <= comp_wr ? lat_dest : dest_reg;
      write_data_reg <= comp_wr ? (lat_wb[0] ? dmem_rdata : dmem_addr) : alu_result;
      mem_error      <= abort;
      if (accept && is_mem) begin
        state      <= ACCESS;
        dmem_req   <= 1'b1;
        dmem_we    <= m[0] && !m[1];
        dmem_addr  <= alu_result;
        dmem_wdata <= store_data;
        lat_load   <= m[1];
        lat_wb     <= wb;
        lat_dest   <= dest_reg;
      end else if (done || abort) begin
        state    <= IDLE;
        dmem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_writeback.sv
// tb_mem_writeback: directed stimulus with a transaction-level model checked every cycle.
module tb_mem_writeback;
  localparam int TO = 4;
`ifdef MEM_WB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif
  logic        clk = 0, rst = 0;
  logic        in_valid = 0;
  logic [2:0]  m = 0;
  logic [1:0]  wb = 0;
  logic [31:0] alu_result = 0, store_data = 0;
  logic [4:0]  dest_reg = 0;
  logic        hold_mem, dmem_req, dmem_we, dmem_ready = 0, reg_write, mem_error;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0, write_data_reg;
  logic [4:0]  write_register;
  int checks = 0, failures = 0;

  mem_writeback #(.TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .m(m), .wb(wb),
    .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg),
    .hold_mem(hold_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .reg_write(reg_write), .write_register(write_register),
    .write_data_reg(write_data_reg), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding access record plus the write the next cycle must show.
  typedef struct {
    bit          load, we;
    logic [31:0] addr, wdata;
    logic [4:0]  dest;
    logic [1:0]  wb;
  } acc_t;
  bit          busy, e_rw, e_err;
  acc_t        cur;
  int          waited;
  logic [4:0]  e_wr;
  logic [31:0] e_wd;

  function automatic bit load_will_write();
    return cur.load && cur.wb[1] && cur.dest != 0;
  endfunction

  function automatic bit exp_hold();
    if (!busy) return 1'b0;
    if (!dmem_ready) return 1'b1;
    return load_will_write() && in_valid && m[1:0] == 2'b00 && wb[1] && dest_reg != 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy = 0; e_rw = 0; e_err = 0; waited = 0;
    end else begin
      bit acc, memop, fin, abrt;
      acc   = in_valid && !exp_hold();
      memop = m[1] || m[0];
      fin   = busy && dmem_ready;
      abrt  = TIMEOUT && busy && !dmem_ready && waited == TO - 1;
      e_err = abrt;
      e_rw  = 0;
      if (fin && load_will_write()) begin
        e_rw = 1; e_wr = cur.dest; e_wd = cur.wb[0] ? dmem_rdata : cur.addr;
      end else if (acc && !memop && wb[1] && dest_reg != 0) begin
        e_rw = 1; e_wr = dest_reg; e_wd = alu_result;
      end
      waited = (busy && !dmem_ready && !abrt) ? waited + 1 : 0;
      if (acc && memop) begin
        busy = 1;
        cur.load = m[1]; cur.we = m[0] && !m[1];
        cur.addr = alu_result; cur.wdata = store_data; cur.dest = dest_reg; cur.wb = wb;
      end else if (fin || abrt) busy = 0;
    end
  end

  always @(negedge clk) begin
    chk("hold_mem", {31'd0, hold_mem}, {31'd0, exp_hold()});
    chk("reg_write", {31'd0, reg_write}, {31'd0, e_rw});
    chk("mem_error", {31'd0, mem_error}, {31'd0, e_err});
    chk("dmem_req", {31'd0, dmem_req}, {31'd0, busy});
    if (e_rw) begin
      chk("write_register", {27'd0, write_register}, {27'd0, e_wr});
      chk("write_data_reg", write_data_reg, e_wd);
    end
    if (busy) begin
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, cur.we});
      chk("dmem_addr", dmem_addr, cur.addr);
      chk("dmem_wdata", dmem_wdata, cur.wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] mm, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d);
    in_valid = v; m = mm; wb = w; alu_result = a; store_data = sd; dest_reg = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) tick();
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_hold", {31'd0, hold_mem}, 32'd0);
    chk("rst_wdata", write_data_reg, 32'd0);
    chk("rst_mem_error", {31'd0, mem_error}, 32'd0);
    rst = 1;
    tick();
    // ADD r5 = 0x22
    drive(1, 3'b000, 2'b10, 32'h22, 0, 5'd5); tick();
    in_valid = 0;
    chk("add_rw", {31'd0, reg_write}, 32'd1);
    chk("add_reg", {27'd0, write_register}, 32'd5);
    chk("add_data", write_data_reg, 32'h22);
    tick();
    chk("add_one_pulse", {31'd0, reg_write}, 32'd0);
    // LW r9 <- [0x40], ready in third request cycle
    drive(1, 3'b010, 2'b11, 32'h40, 0, 5'd9); tick();
    in_valid = 0;
    chk("lw_req", {31'd0, dmem_req}, 32'd1);
    chk("lw_we", {31'd0, dmem_we}, 32'd0);
    chk("lw_addr", dmem_addr, 32'h40);
    chk("lw_hold1", {31'd0, hold_mem}, 32'd1);
    tick();
    chk("lw_hold2", {31'd0, hold_mem}, 32'd1);
    tick();
    dmem_ready = 1; dmem_rdata = 32'hDEADBEEF; #1;
    chk("lw_hold_ready", {31'd0, hold_mem}, 32'd0);
    tick();
    dmem_ready = 0;
    chk("lw_rw", {31'd0, reg_write}, 32'd1);
    chk("lw_reg", {27'd0, write_register}, 32'd9);
    chk("lw_data", write_data_reg, 32'hDEADBEEF);
    chk("lw_req_drop", {31'd0, dmem_req}, 32'd0);
    // SW [0x10] = 0x1234, ready at once
    drive(1, 3'b001, 2'b00, 32'h10, 32'h1234, 5'd0); tick();
    in_valid = 0; dmem_ready = 1; #1;
    chk("sw_we", {31'd0, dmem_we}, 32'd1);
    chk("sw_wdata", dmem_wdata, 32'h1234);
    chk("sw_addr", dmem_addr, 32'h10);
    chk("sw_hold", {31'd0, hold_mem}, 32'd0);
    tick();
    dmem_ready = 0;
    chk("sw_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("sw_no_write", {31'd0, reg_write}, 32'd0);
    // ADDI to $0, then BEQ
    drive(1, 3'b000, 2'b10, 32'h7, 0, 5'd0); tick();
    in_valid = 0;
    chk("r0_suppressed", {31'd0, reg_write}, 32'd0);
    drive(1, 3'b100, 2'b00, 32'h44, 32'h5, 5'd2); tick();
    in_valid = 0;
    chk("beq_no_req", {31'd0, dmem_req}, 32'd0);
    chk("beq_no_write", {31'd0, reg_write}, 32'd0);
    // writing load completes while a writing ADD waits: ADD held one cycle
    drive(1, 3'b010, 2'b11, 32'h80, 0, 5'd3); tick();
    dmem_ready = 1; dmem_rdata = 32'hAAAA5555;
    drive(1, 3'b000, 2'b10, 32'h99, 0, 5'd4); #1;
    chk("conflict_hold", {31'd0, hold_mem}, 32'd1);
    tick();
    dmem_ready = 0;
    chk("conflict_load_reg", {27'd0, write_register}, 32'd3);
    chk("conflict_load_data", write_data_reg, 32'hAAAA5555);
    tick();
    in_valid = 0;
    chk("conflict_add_reg", {27'd0, write_register}, 32'd4);
    chk("conflict_add_data", write_data_reg, 32'h99);
    // store completes alongside a writing ADD
    drive(1, 3'b001, 2'b00, 32'h20, 32'h55, 5'd0); tick();
    dmem_ready = 1;
    drive(1, 3'b000, 2'b10, 32'h66, 0, 5'd6); #1;
    chk("sw_add_hold", {31'd0, hold_mem}, 32'd0);
    tick();
    in_valid = 0; dmem_ready = 0;
    chk("sw_add_reg", {27'd0, write_register}, 32'd6);
    chk("sw_add_data", write_data_reg, 32'h66);
    // back-to-back loads
    drive(1, 3'b010, 2'b11, 32'h100, 0, 5'd7); tick();
    dmem_ready = 1; dmem_rdata = 32'h11;
    drive(1, 3'b010, 2'b11, 32'h104, 0, 5'd8); tick();
    in_valid = 0; dmem_rdata = 32'h22;
    chk("b2b_data1", write_data_reg, 32'h11);
    chk("b2b_addr2", dmem_addr, 32'h104);
    tick();
    dmem_ready = 0;
    chk("b2b_data2", write_data_reg, 32'h22);
    chk("b2b_reg2", {27'd0, write_register}, 32'd8);
    // reset during an access
    drive(1, 3'b010, 2'b11, 32'h200, 0, 5'd10); tick();
    in_valid = 0;
    tick();
    #2 rst = 0; #1;
    chk("rst_async_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_async_hold", {31'd0, hold_mem}, 32'd0);
    tick();
    rst = 1; dmem_ready = 1; dmem_rdata = 32'hBAD;
    tick();
    chk("rst_no_wb", {31'd0, reg_write}, 32'd0);
    tick();
    chk("rst_no_wb2", {31'd0, reg_write}, 32'd0);
    dmem_ready = 0;
    // ready never arrives
    drive(1, 3'b010, 2'b11, 32'h300, 0, 5'd11); tick();
    in_valid = 0;
    n = 0;
    while (dmem_req === 1'b1 && n < 20) begin n++; tick(); end
`ifdef MEM_WB_TIMEOUT_EN
    chk("to_req_cycles", n, TO);
    chk("to_error", {31'd0, mem_error}, 32'd1);
    chk("to_hold", {31'd0, hold_mem}, 32'd0);
    tick();
    chk("to_error_pulse", {31'd0, mem_error}, 32'd0);
    chk("to_no_wb", {31'd0, reg_write}, 32'd0);
`else
    chk("wait_forever", n, 20);
    chk("no_error", {31'd0, mem_error}, 32'd0);
    dmem_ready = 1; dmem_rdata = 32'h33;
    tick();
    dmem_ready = 0;
    chk("late_wb_data", write_data_reg, 32'h33);
`endif
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
